adder_share_arb: RTL and testbench
==================================

# adder_share_arb

Round-robin arbiter that time-shares one signed `adder2` datapath instance among `NREQ` requesters, e.g. the neuron-sum paths of one network layer. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle and registers the sum with the requester's index and a signed-overflow flag. A single output register with backpressure sustains one addition per cycle while the consumer keeps `res_ready` high.

## Interface
- `DWIDTH`, 32, operand/result width (signed two's complement)
- `NREQ`, 4, number of requesters (2..16)
- `TWIDTH`, 2, requester index width, equal to ceil(log2(NREQ))

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  bit i asserts requester i's operands
- `req_a`  in  NREQ*DWIDTH  operand a; requester i uses bits [i*DWIDTH +: DWIDTH]
- `req_b`  in  NREQ*DWIDTH  operand b, packed the same way
- `req_ready`  out  NREQ  one-hot or zero grant; transfer on `req_valid[i] & req_ready[i]`
- `res_valid`  out  1  output register holds a result
- `res_data`  out  DWIDTH  a+b, wrapped modulo 2^DWIDTH
- `res_id`  out  TWIDTH  index of the requester that produced `res_data`
- `res_ovf`  out  1  signed overflow of that addition
- `res_ready`  in  1  consumer accepts the result on `res_valid & res_ready`

## Operation
- State is the output-register occupancy: EMPTY (`res_valid`=0) or FULL (`res_valid`=1).
- `can_accept` = ~`res_valid` | `res_ready`.
- Grant: if `can_accept`, `req_ready` is one-hot on the first asserted `req_valid` bit, searching from `ptr` upward and wrapping at `NREQ`-1 to 0. Otherwise `req_ready` is all zero.
- `req_ready` is combinational from `req_valid`, `ptr`, `res_valid` and `res_ready`. It never depends on the operand values.
- Round-robin pointer:
  - On a grant to requester g, `ptr` ← (g+1) mod `NREQ`.
  - With no grant, `ptr` holds.
  - Reset value is 0, so requester 0 has highest priority after reset.
- On a grant, the output register loads:
  - `res_data` = a+b, truncated to `DWIDTH`.
  - `res_id` = g.
  - `res_ovf` = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
- Transitions:
  - EMPTY + grant → FULL.
  - FULL + `res_ready` + grant → FULL, with the new data loaded.
  - FULL + `res_ready` + no grant → EMPTY.
  - FULL + ~`res_ready` → FULL; data held stable, no grant.
- Requester obligations: a requester keeps `req_valid` and its operands stable until accepted. A requester may deassert `req_valid` only after the accepting edge.
- Non-requesting slots are skipped with no idle cycles.

## Timing
- Latency: the result is visible one cycle after the accepting edge.
- Throughput: 1 result/cycle while `res_ready`=1. Each requester is served at least once every `NREQ` grants.
- Reset, asynchronous and immediate: `res_valid`=0, `res_data`=0, `res_id`=0, `res_ovf`=0, `ptr`=0. `req_ready` then evaluates to 0 for all requesters when `req_valid`=0.
- Reset mid-operation: any held result is discarded. A requester whose transfer had not completed must retry.
- `res_data`, `res_id` and `res_ovf` hold their values while `res_valid`=0. They have no meaning in that state.

## Structure
- A shared package holds the `DWIDTH` default, a clog2 function, and the FSM encoding EMPTY=1'b0, FULL=1'b1.
- The sub-module `rr_arbiter` (NREQ, TWIDTH; inputs `req`, `en`; outputs `gnt`, `gnt_id`, `gnt_any`) owns `ptr`.
- The top level:
  - muxes the operands by `gnt_id`;
  - instantiates `adder2` for the sum;
  - owns the output register and the overflow logic.

## Test plan
1. Reset behaviour: pulse `rst_n` low mid-cycle → all outputs 0 immediately and `ptr`=0. After release, requester 0 with a=5, b=7 gives `res_data`=12, `res_id`=0 one cycle later.
2. Fairness: all 4 requesters valid continuously, `res_ready`=1 → `res_id` sequence 0,1,2,3,0,1… with no gaps. Then drop requester 2 → sequence 3,0,1,3,….
3. Backpressure: FULL with `res_ready`=0 for 5 cycles → `res_data` stable and `req_ready`=0. On release, the next grant occurs in that same cycle with no bubble.
4. Overflow and wrap:
   - 0x7FFFFFFF+1 → `res_data`=0x80000000, `res_ovf`=1.
   - 0x80000000+0xFFFFFFFF → 0x7FFFFFFF, `res_ovf`=1.
   - (-3)+5 → 2, `res_ovf`=0.
5. Sparse traffic: a single request from requester 3 every 3rd cycle → `res_valid` pulses for 1 cycle each with `res_id`=3. `ptr` wraps to 0 after each grant.
6. Random stress: random valid/ready and operands against a reference queue model → no lost or duplicated results, every sum matches, no requester starved longer than `NREQ` grants.

Source files
------------

// File: rtl/adder_share_arb_pkg.sv
// Shared definitions for the time-shared adder arbiter: default width,
// a constant clog2 helper and the output-register occupancy encoding.
package adder_share_arb_pkg;

  localparam int DWIDTH_DEF = 32;

  // Number of bits needed to index n items (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } occ_state_t;

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester and result handshake bundle for adder_share_arb.
// master: requesters plus result consumer; slave: the arbiter itself.
interface adder_share_arb_if
  import adder_share_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int TWIDTH = clog2(NREQ)
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_a;
  logic [NREQ*DWIDTH-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic                   res_valid;
  logic [DWIDTH-1:0]      res_data;
  logic [TWIDTH-1:0]      res_id;
  logic                   res_ovf;
  logic                   res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, res_ovf
  );

endinterface

// File: rtl/adder_share_arb_adder2.sv
// Plain two-operand signed adder; the sum wraps modulo 2^DWIDTH.
module adder2 #(
  parameter int DWIDTH = 32
) (
  input  logic signed [DWIDTH-1:0] a,
  input  logic signed [DWIDTH-1:0] b,
  output logic signed [DWIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping,
// and moves ptr just past the winner so every requester gets a turn.
module rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int TWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic              en,
  output logic [NREQ-1:0]   gnt,
  output logic [TWIDTH-1:0] gnt_id,
  output logic              gnt_any
);

  logic [TWIDTH-1:0] ptr;
  logic [TWIDTH-1:0] idx;
  int                pos;

  // Search from ptr upward, wrapping at NREQ-1; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    pos     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = TWIDTH'(pos);
      if (en && !gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_id   = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  // Pointer advances past the granted requester; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      if (int'(gnt_id) == NREQ - 1) ptr <= '0;
      else                          ptr <= gnt_id + TWIDTH'(1);
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Time-shares one adder2 among NREQ requesters. The single output register
// is the only storage; a new sum loads whenever it is empty or being drained,
// giving one result per cycle under continuous res_ready.
//
// state    | meaning
// ST_EMPTY | output register holds no result (res_valid=0)
// ST_FULL  | output register holds a result awaiting res_ready
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NREQ   = 4,
  parameter int TWIDTH = clog2(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  adder_share_arb_if.slave bus
);

  occ_state_t        state;
  logic [DWIDTH-1:0] data_q;
  logic [TWIDTH-1:0] id_q;
  logic              ovf_q;

  logic              can_accept;
  logic [NREQ-1:0]   gnt;
  logic [TWIDTH-1:0] gnt_id;
  logic              gnt_any;
  logic [DWIDTH-1:0] a_sel;
  logic [DWIDTH-1:0] b_sel;
  logic [DWIDTH-1:0] sum;
  logic              ovf;

  assign can_accept = (state == ST_EMPTY) || bus.res_ready;

  rr_arbiter #(
    .NREQ   (NREQ),
    .TWIDTH (TWIDTH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .en      (can_accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Route the granted requester's operands to the shared adder.
  always_comb begin
    a_sel = bus.req_a[int'(gnt_id)*DWIDTH +: DWIDTH];
    b_sel = bus.req_b[int'(gnt_id)*DWIDTH +: DWIDTH];
  end

  adder2 #(
    .DWIDTH (DWIDTH)
  ) u_add (
    .a   (a_sel),
    .b   (b_sel),
    .sum (sum)
  );

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign ovf = (a_sel[DWIDTH-1] == b_sel[DWIDTH-1]) &&
               (sum[DWIDTH-1] != a_sel[DWIDTH-1]);

  // Occupancy FSM and output register; payload only changes on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      id_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (gnt_any) begin
            state  <= ST_FULL;
            data_q <= sum;
            id_q   <= gnt_id;
            ovf_q  <= ovf;
          end
        end
        ST_FULL: begin
          if (gnt_any) begin
            data_q <= sum;
            id_q   <= gnt_id;
            ovf_q  <= ovf;
          end else if (bus.res_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.req_ready = gnt;
  assign bus.res_valid = (state == ST_FULL);
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;
  assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed reset/fairness/backpressure/sparse
// sequences, a table of overflow vectors and a randomized scoreboard run.
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  adder_share_arb_if #(.NREQ(NREQ), .DWIDTH(DW), .TWIDTH(TW)) bus ();

  adder_share_arb #(.DWIDTH(DW), .NREQ(NREQ), .TWIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] op_a [NREQ];
  logic [DW-1:0] op_b [NREQ];

  typedef struct {
    logic [DW-1:0] data;
    int            id;
    logic          ovf;
  } res_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            id;
    logic [DW-1:0] exp_sum;
    logic          exp_ovf;
  } vec_t;

  res_t          exp_q[$];
  logic [NREQ-1:0] pending;
  int            waitg [NREQ];
  int            m_ptr;
  bit            m_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return s[DW-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic chk_res(input string tag, input int id);
    check({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    check({tag, "_id"},    64'(bus.res_id), 64'(id));
    check({tag, "_data"},  64'(bus.res_data), 64'(ref_sum(op_a[id], op_b[id])));
    check({tag, "_ovf"},   64'(bus.res_ovf), 64'(ref_ovf(op_a[id], op_b[id])));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stress_cycle(input bit allow_new, input bit force_ready);
    int   g;
    logic rr;
    res_t r;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!pending[i] && allow_new && ($urandom_range(0, 1) == 1)) begin
        pending[i] = 1'b1;
        waitg[i] = 0;
        set_req(i, rand_op(), rand_op());
      end
    end
    rr = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.req_valid = pending;
    bus.res_ready = rr;
    #1;
    check("st_res_valid", 64'(bus.res_valid), 64'(m_full));
    if (m_full) begin
      check("st_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check("st_res_data", 64'(bus.res_data), 64'(exp_q[0].data));
        check("st_res_id",   64'(bus.res_id),   64'(exp_q[0].id));
        check("st_res_ovf",  64'(bus.res_ovf),  64'(exp_q[0].ovf));
      end
    end
    g = (m_full && !rr) ? -1 : ref_grant(pending, m_ptr);
    check("st_req_ready", 64'(bus.req_ready), 64'(onehot(g)));
    if (m_full && rr && exp_q.size() > 0) void'(exp_q.pop_front());
    if (g >= 0) begin
      check("st_starve", 64'(waitg[g] <= NREQ - 1), 64'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (pending[i] && i != g) waitg[i]++;
      end
      r.data = ref_sum(op_a[g], op_b[g]);
      r.id   = g;
      r.ovf  = ref_ovf(op_a[g], op_b[g]);
      exp_q.push_back(r);
      pending[g] = 1'b0;
      m_ptr = (g + 1) % NREQ;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs [7];
    int   fair2 [6];
    int   prev;

    vecs[0] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, id: 0, exp_sum: 32'h8000_0000, exp_ovf: 1'b1};
    vecs[1] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, id: 1, exp_sum: 32'h7FFF_FFFF, exp_ovf: 1'b1};
    vecs[2] = '{a: 32'hFFFF_FFFD, b: 32'h0000_0005, id: 2, exp_sum: 32'h0000_0002, exp_ovf: 1'b0};
    vecs[3] = '{a: 32'h0000_0005, b: 32'h0000_0007, id: 3, exp_sum: 32'h0000_000C, exp_ovf: 1'b0};
    vecs[4] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, id: 0, exp_sum: 32'hFFFF_FFFE, exp_ovf: 1'b0};
    vecs[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, id: 2, exp_sum: 32'h0000_0000, exp_ovf: 1'b1};
    vecs[6] = '{a: 32'h4000_0000, b: 32'h4000_0000, id: 3, exp_sum: 32'h8000_0000, exp_ovf: 1'b1};
    fair2 = '{0, 1, 3, 0, 1, 3};

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset from power-up
    #3 rst_n = 1'b0;
    #1;
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data",  64'(bus.res_data), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First transaction after reset, then hold it and reset mid-cycle
    @(negedge clk);
    set_req(0, 32'd5, 32'd7);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    #1;
    chk_res("first", 0);
    check("first_sum12", 64'(bus.res_data), 64'd12);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_data",  64'(bus.res_data), 64'd0);
    check("midrst_id",    64'(bus.res_id), 64'd0);
    check("midrst_ovf",   64'(bus.res_ovf), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness with all requesters valid: 0,1,2,3,0,1,2,3
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 16 + 1), 32'(i + 100));
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fair_ready", 64'(bus.req_ready), 64'(onehot(c % NREQ)));
      if (c > 0) chk_res("fair_res", (c - 1) % NREQ);
      @(negedge clk);
    end
    prev = 3;
    bus.req_valid = 4'b1011;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("fair2_ready", 64'(bus.req_ready), 64'(onehot(fair2[c])));
      chk_res("fair2_res", prev);
      prev = fair2[c];
      @(negedge clk);
    end
    bus.req_valid = '0;
    #1;
    chk_res("fair2_last", prev);

    // Backpressure: hold a result five cycles, then release with same-cycle grant
    @(negedge clk);
    set_req(1, 32'd100, 32'd200);
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b1;
    @(negedge clk);
    set_req(2, 32'h10, 32'h20);
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready_low", 64'(bus.req_ready), 64'd0);
      chk_res("bp_hold", 1);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.req_ready), 64'(4'b0100));
    check("bp_release_data", 64'(bus.res_data), 64'd300);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk_res("bp_next", 2);
    check("bp_next_data", 64'(bus.res_data), 64'h30);

    // Overflow / wrap vectors
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      bus.req_valid = onehot(vecs[v].id);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      check("vec_valid", 64'(bus.res_valid), 64'd1);
      check("vec_data",  64'(bus.res_data), 64'(vecs[v].exp_sum));
      check("vec_ovf",   64'(bus.res_ovf), 64'(vecs[v].exp_ovf));
      check("vec_id",    64'(bus.res_id), 64'(vecs[v].id));
    end

    // Sparse traffic from requester 3 every third cycle
    for (int rep = 0; rep < 4; rep++) begin
      @(negedge clk);
      set_req(3, 32'(rep * 3), 32'(rep + 40));
      bus.req_valid = 4'b1000;
      bus.res_ready = 1'b1;
      #1;
      check("sparse_ready", 64'(bus.req_ready), 64'(4'b1000));
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk_res("sparse_res", 3);
      @(negedge clk);
      #1;
      check("sparse_idle", 64'(bus.res_valid), 64'd0);
    end
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    check("sparse_ptr_wrap", 64'(bus.req_ready), 64'(4'b0001));
    @(negedge clk);
    bus.req_valid = '0;

    // Randomized run against the scoreboard model
    do_reset();
    m_full = 1'b0;
    m_ptr = 0;
    pending = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) waitg[i] = 0;
    for (int c = 0; c < 3000; c++) stress_cycle(1'b1, 1'b0);
    for (int c = 0; c < 3 * NREQ; c++) stress_cycle(1'b0, 1'b1);
    check("st_drained_q", 64'(exp_q.size()), 64'd0);
    check("st_drained_pending", 64'(pending), 64'd0);
    #1;
    check("st_drained_valid", 64'(bus.res_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
